// File: rtl/alu_issue_ctrl.sv
// Issue controller: 2-entry op FIFO feeding the ALU, with multi-cycle hold and branch flush.
// Payload is combinational from the FIFO head; a mem_blocked stall freezes the head op and the FSM.
module alu_issue_ctrl #(
    parameter int unsigned MC_LAT    = 3,
    parameter logic [9:0]  MC_OPCODE = 10'h1AF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [9:0]  dec_opcode,
    input  logic [63:0] dec_oprd1,
    input  logic [63:0] dec_oprd2,
    input  logic [63:0] dec_oprd3,
    input  logic [63:0] dec_next_rip,
    output logic        alu_enable,
    output logic [9:0]  alu_opcode,
    output logic [63:0] alu_oprd1,
    output logic [63:0] alu_oprd2,
    output logic [63:0] alu_oprd3,
    output logic [63:0] alu_next_rip,
    input  logic        mem_blocked,
    input  logic        branch,
    input  logic [63:0] branch_rip,
    output logic        flush,
    output logic [63:0] redirect_rip,
    output logic [31:0] issued_cnt
);

    typedef struct packed {
        logic [9:0]  opcode;
        logic [63:0] oprd1;
        logic [63:0] oprd2;
        logic [63:0] oprd3;
        logic [63:0] next_rip;
    } op_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] MC_LAST = 4'(MC_LAT - 1);

    state_t      state_q, state_d;
    op_t         fifo_q [2];
    op_t         fifo_d [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  mc_cnt_q, mc_cnt_d;
    logic        flush_q, flush_d;
    logic [63:0] redirect_rip_q, redirect_rip_d;
    logic [31:0] issued_cnt_q, issued_cnt_d;

    op_t  head_op;
    op_t  in_op;
    logic push;
    logic pop;
    logic head_is_mc;

    always_comb begin
        in_op.opcode   = dec_opcode;
        in_op.oprd1    = dec_oprd1;
        in_op.oprd2    = dec_oprd2;
        in_op.oprd3    = dec_oprd3;
        in_op.next_rip = dec_next_rip;
    end

    assign head_op    = (count_q != 2'd0) ? fifo_q[head_q] : '0;
    assign head_is_mc = (head_op.opcode == MC_OPCODE);

    // Ready depends only on registered state so decode never sees a pop-dependent path.
    assign dec_ready  = (count_q < 2'd2) && (state_q != FLUSH);
    assign alu_enable = (count_q != 2'd0) && (state_q != FLUSH) && !branch;
    assign push       = dec_valid && dec_ready && !branch;
    assign pop        = alu_enable && !mem_blocked &&
                        ((state_q == RUN) ? !head_is_mc : (mc_cnt_q == MC_LAST));

    assign alu_opcode   = head_op.opcode;
    assign alu_oprd1    = head_op.oprd1;
    assign alu_oprd2    = head_op.oprd2;
    assign alu_oprd3    = head_op.oprd3;
    assign alu_next_rip = head_op.next_rip;

    assign flush        = flush_q;
    assign redirect_rip = redirect_rip_q;
    assign issued_cnt   = issued_cnt_q;

    always_comb begin
        state_d        = state_q;
        fifo_d[0]      = fifo_q[0];
        fifo_d[1]      = fifo_q[1];
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        mc_cnt_d       = mc_cnt_q;
        flush_d        = 1'b0;
        redirect_rip_d = redirect_rip_q;
        issued_cnt_d   = issued_cnt_q + {31'd0, pop};

        if (branch) begin
            state_d        = FLUSH;
            head_d         = 1'b0;
            tail_d         = 1'b0;
            count_d        = 2'd0;
            mc_cnt_d       = 4'd0;
            flush_d        = 1'b1;
            redirect_rip_d = branch_rip;
        end else begin
            if (push) begin
                fifo_d[tail_q] = in_op;
                tail_d         = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};

            case (state_q)
                RUN: begin
                    if (alu_enable && !mem_blocked && head_is_mc) begin
                        state_d  = MULTI;
                        mc_cnt_d = 4'd1;
                    end
                end
                MULTI: begin
                    if (!mem_blocked) begin
                        if (mc_cnt_q == MC_LAST) begin
                            state_d  = RUN;
                            mc_cnt_d = 4'd0;
                        end else begin
                            mc_cnt_d = mc_cnt_q + 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= RUN;
            fifo_q[0]      <= '0;
            fifo_q[1]      <= '0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            count_q        <= 2'd0;
            mc_cnt_q       <= 4'd0;
            flush_q        <= 1'b0;
            redirect_rip_q <= 64'd0;
            issued_cnt_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            fifo_q[0]      <= fifo_d[0];
            fifo_q[1]      <= fifo_d[1];
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            mc_cnt_q       <= mc_cnt_d;
            flush_q        <= flush_d;
            redirect_rip_q <= redirect_rip_d;
            issued_cnt_q   <= issued_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [9:0]  dec_opcode;
    logic [63:0] dec_oprd1;
    logic [63:0] dec_oprd2;
    logic [63:0] dec_oprd3;
    logic [63:0] dec_next_rip;
    logic        alu_enable;
    logic [9:0]  alu_opcode;
    logic [63:0] alu_oprd1;
    logic [63:0] alu_oprd2;
    logic [63:0] alu_oprd3;
    logic [63:0] alu_next_rip;
    logic        mem_blocked;
    logic        branch;
    logic [63:0] branch_rip;
    logic        flush;
    logic [63:0] redirect_rip;
    logic [31:0] issued_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.MC_LAT(3), .MC_OPCODE(10'h1AF)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_opcode   (dec_opcode),
        .dec_oprd1    (dec_oprd1),
        .dec_oprd2    (dec_oprd2),
        .dec_oprd3    (dec_oprd3),
        .dec_next_rip (dec_next_rip),
        .alu_enable   (alu_enable),
        .alu_opcode   (alu_opcode),
        .alu_oprd1    (alu_oprd1),
        .alu_oprd2    (alu_oprd2),
        .alu_oprd3    (alu_oprd3),
        .alu_next_rip (alu_next_rip),
        .mem_blocked  (mem_blocked),
        .branch       (branch),
        .branch_rip   (branch_rip),
        .flush        (flush),
        .redirect_rip (redirect_rip),
        .issued_cnt   (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [9:0] op, input logic [63:0] o1, input logic [63:0] o2,
                            input logic [63:0] rip);
        dec_valid    = 1'b1;
        dec_opcode   = op;
        dec_oprd1    = o1;
        dec_oprd2    = o2;
        dec_oprd3    = 64'd0;
        dec_next_rip = rip;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; dec_valid = 1'b0; dec_opcode = '0; dec_oprd1 = '0; dec_oprd2 = '0;
        dec_oprd3 = '0; dec_next_rip = '0; mem_blocked = 1'b0; branch = 1'b0; branch_rip = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_en", alu_enable, 0);
        check_val("rst_issued", issued_cnt, 0);
        check_val("rst_flush", flush, 0);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check_val("rst_ready", dec_ready, 1);
        check_val("rst_op", alu_opcode, 0);
        check_val("rst_redirect", redirect_rip, 0);

        // Single-cycle op
        drive_op(10'h001, 64'd5, 64'd7, 64'h1000); #1;
        check_val("add_ready", dec_ready, 1);
        check_val("add_idle_en", alu_enable, 0);
        @(negedge clk); dec_valid = 1'b0; #1;
        check_val("add_en", alu_enable, 1);
        check_val("add_op", alu_opcode, 10'h001);
        check_val("add_oprd1", alu_oprd1, 5);
        check_val("add_oprd2", alu_oprd2, 7);
        check_val("add_rip", alu_next_rip, 64'h1000);
        @(negedge clk); #1;
        check_val("add_done_en", alu_enable, 0);
        check_val("add_done_op", alu_opcode, 0);
        check_val("add_issued", issued_cnt, 1);

        // Multi-cycle op held for MC_LAT cycles
        drive_op(10'h1AF, 64'd3, 64'd9, 64'h2000);
        @(negedge clk); dec_valid = 1'b0; #1;
        check_val("mc_en1", alu_enable, 1);
        check_val("mc_op1", alu_opcode, 10'h1AF);
        check_val("mc_oprd1_1", alu_oprd1, 3);
        @(negedge clk); #1;
        check_val("mc_en2", alu_enable, 1);
        check_val("mc_oprd2_2", alu_oprd2, 9);
        check_val("mc_issued2", issued_cnt, 1);
        @(negedge clk); #1;
        check_val("mc_en3", alu_enable, 1);
        check_val("mc_oprd1_3", alu_oprd1, 3);
        check_val("mc_issued3", issued_cnt, 1);
        @(negedge clk); #1;
        check_val("mc_done_en", alu_enable, 0);
        check_val("mc_issued", issued_cnt, 2);

        // Back-to-back pushes under a 4-cycle stall
        mem_blocked = 1'b1;
        drive_op(10'h002, 64'd11, 64'd0, 64'h3000);
        @(negedge clk); drive_op(10'h003, 64'd22, 64'd0, 64'h3008); #1;
        check_val("blk_en1", alu_enable, 1);
        check_val("blk_op1", alu_opcode, 10'h002);
        @(negedge clk); dec_valid = 1'b0; #1;
        check_val("blk_ready2", dec_ready, 0);
        check_val("blk_en2", alu_enable, 1);
        check_val("blk_oprd1_2", alu_oprd1, 11);
        @(negedge clk); #1;
        check_val("blk_ready3", dec_ready, 0);
        check_val("blk_op3", alu_opcode, 10'h002);
        check_val("blk_issued3", issued_cnt, 2);
        @(negedge clk); mem_blocked = 1'b0; #1;
        check_val("rel_en1", alu_enable, 1);
        check_val("rel_op1", alu_opcode, 10'h002);
        @(negedge clk); #1;
        check_val("rel_en2", alu_enable, 1);
        check_val("rel_op2", alu_opcode, 10'h003);
        check_val("rel_oprd1_2", alu_oprd1, 22);
        check_val("rel_issued2", issued_cnt, 3);
        @(negedge clk); #1;
        check_val("rel_en3", alu_enable, 0);
        check_val("rel_issued3", issued_cnt, 4);
        check_val("rel_ready3", dec_ready, 1);

        // Branch with the FIFO full
        mem_blocked = 1'b1;
        drive_op(10'h004, 64'd1, 64'd2, 64'h4000);
        @(negedge clk); drive_op(10'h005, 64'd3, 64'd4, 64'h4008);
        @(negedge clk); dec_valid = 1'b0; #1;
        check_val("full_ready", dec_ready, 0);
        branch = 1'b1; branch_rip = 64'h400080; #1;
        check_val("br_en_mask", alu_enable, 0);
        @(negedge clk); branch = 1'b0; mem_blocked = 1'b0; #1;
        check_val("fl_flush", flush, 1);
        check_val("fl_redirect", redirect_rip, 64'h400080);
        check_val("fl_ready", dec_ready, 0);
        check_val("fl_en", alu_enable, 0);
        check_val("fl_op", alu_opcode, 0);
        @(negedge clk); #1;
        check_val("fl_after_flush", flush, 0);
        check_val("fl_after_ready", dec_ready, 1);
        check_val("fl_after_en", alu_enable, 0);
        check_val("fl_issued", issued_cnt, 4);

        // Branch discards a same-cycle push, then re-branch during FLUSH
        drive_op(10'h006, 64'd6, 64'd6, 64'h5000);
        branch = 1'b1; branch_rip = 64'h500000;
        @(negedge clk); dec_valid = 1'b0; branch_rip = 64'h600000; #1;
        check_val("rb_flush1", flush, 1);
        check_val("rb_redirect1", redirect_rip, 64'h500000);
        @(negedge clk); branch = 1'b0; #1;
        check_val("rb_flush2", flush, 1);
        check_val("rb_redirect2", redirect_rip, 64'h600000);
        @(negedge clk); #1;
        check_val("rb_flush3", flush, 0);
        check_val("rb_discard_en", alu_enable, 0);
        check_val("rb_issued", issued_cnt, 4);

        // Reset in the middle of a multi-cycle op
        drive_op(10'h1AF, 64'd1, 64'd2, 64'h7000);
        @(negedge clk); dec_valid = 1'b0; #1;
        check_val("mr_en1", alu_enable, 1);
        @(negedge clk); reset_n = 1'b0; #1;
        check_val("mr_en2", alu_enable, 1);
        check_val("mr_oprd1", alu_oprd1, 1);
        @(negedge clk); #1;
        check_val("mr_en", alu_enable, 0);
        check_val("mr_op", alu_opcode, 0);
        check_val("mr_issued", issued_cnt, 0);
        check_val("mr_flush", flush, 0);
        check_val("mr_redirect", redirect_rip, 0);
        check_val("mr_ready", dec_ready, 1);
        reset_n = 1'b1;
        @(negedge clk); #1;
        check_val("mr_post_en", alu_enable, 0);
        check_val("mr_post_issued", issued_cnt, 0);

        // Issue counter wrap
        drive_op(10'h001, 64'd1, 64'd1, 64'h8000);
        force dut.issued_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.issued_cnt_q;
        #1;
        check_val("wrap_preload", issued_cnt, 32'hFFFF_FFFF);
        @(negedge clk); dec_valid = 1'b0; #1;
        check_val("wrap_en", alu_enable, 1);
        @(negedge clk); #1;
        check_val("wrap_issued", issued_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
